// File: rtl/delay_line.sv
// Purpose: programmable delay line; LANES x WIDTH beats delayed by D advance cycles (1..MAX_DEPTH).
// Latency: D en-cycles from in_* to out_* (D=1 is a single register stage via write-through bypass).
// Backpressure: none; en low freezes the line and holds the outputs, flush/cfg_load override en.
module delay_line #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 4,
    parameter int MAX_DEPTH = 64,
    parameter int BRAM      = 1,
    localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   cfg_load,
    input  logic [DW-1:0]          depth_cfg,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [DW-1:0]          depth,
    output logic                   cfg_err
);

    localparam int AW    = $clog2(MAX_DEPTH);
    localparam int SW    = AW + 2;
    localparam int DAT_W = LANES * WIDTH;

    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        raddr;
    logic [SW-1:0]        rsum;
    logic [MAX_DEPTH-1:0] vld_q, vld_d;
    logic                 out_vld_q, out_vld_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 clr;
    logic                 adv;
    logic [DAT_W-1:0]     dly_dat;

    // Data storage: no reset, qualified entirely by the separate valid flops.
    logic [DAT_W-1:0]     mem [MAX_DEPTH];

    assign clr = flush | cfg_load;
    assign adv = en & ~clr;

    // Read the slot written D-1 advances ago: (wptr - D + 1) mod MAX_DEPTH, any MAX_DEPTH.
    always_comb begin
        rsum = SW'(wptr_q) + SW'(MAX_DEPTH) + SW'(1) - SW'(depth_q);
        if (rsum >= SW'(MAX_DEPTH)) begin
            rsum = rsum - SW'(MAX_DEPTH);
        end
        raddr = AW'(rsum);
    end

    // Control: depth loading with range clamp, valid tracking, pointer advance.
    always_comb begin
        wptr_d    = wptr_q;
        vld_d     = vld_q;
        out_vld_d = out_vld_q;
        depth_d   = depth_q;
        cfg_err_d = cfg_err_q;
        if (cfg_load) begin
            if (depth_cfg == '0) begin
                depth_d   = DW'(1);
                cfg_err_d = 1'b1;
            end else if (depth_cfg > DW'(MAX_DEPTH)) begin
                depth_d   = DW'(MAX_DEPTH);
                cfg_err_d = 1'b1;
            end else begin
                depth_d   = depth_cfg;
                cfg_err_d = 1'b0;
            end
        end
        if (clr) begin
            vld_d     = '0;
            out_vld_d = 1'b0;
        end else if (en) begin
            vld_d[wptr_q] = in_valid;
            out_vld_d     = (depth_q == DW'(1)) ? in_valid : vld_q[raddr];
            wptr_d        = (wptr_q == AW'(MAX_DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            vld_q     <= '0;
            out_vld_q <= 1'b0;
            depth_q   <= DW'(MAX_DEPTH);
            cfg_err_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            vld_q     <= vld_d;
            out_vld_q <= out_vld_d;
            depth_q   <= depth_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Storage write on every accepted advance.
    always_ff @(posedge clk) begin
        if (adv) begin
            mem[wptr_q] <= in_data;
        end
    end

    if (BRAM != 0) begin : g_sync
        logic [DAT_W-1:0] rd_q;
        logic [DAT_W-1:0] byp_q, byp_d;
        logic             byp_sel_q, byp_sel_d;

        // Registered read port, as a block RAM would provide.
        always_ff @(posedge clk) begin
            if (adv) begin
                rd_q <= mem[raddr];
            end
        end

        // For D=1 the slot being read is the one being written; capture the input instead.
        always_comb begin
            byp_d     = byp_q;
            byp_sel_d = byp_sel_q;
            if (adv) begin
                byp_d     = in_data;
                byp_sel_d = (depth_q == DW'(1));
            end
        end

        // Bypass registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                byp_q     <= '0;
                byp_sel_q <= 1'b0;
            end else begin
                byp_q     <= byp_d;
                byp_sel_q <= byp_sel_d;
            end
        end

        assign dly_dat = byp_sel_q ? byp_q : rd_q;
    end else begin : g_async
        logic [DAT_W-1:0] out_dat_q, out_dat_d;

        // Combinational read, bypassed with the live input for D=1, then registered.
        always_comb begin
            out_dat_d = out_dat_q;
            if (adv) begin
                out_dat_d = (depth_q == DW'(1)) ? in_data : mem[raddr];
            end
        end

        // Output data register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                out_dat_q <= '0;
            end else begin
                out_dat_q <= out_dat_d;
            end
        end

        assign dly_dat = out_dat_q;
    end

    // Data is forced to zero when not valid so no uninitialised storage ever reaches the pins.
    assign out_valid = out_vld_q;
    assign out_data  = out_vld_q ? dly_dat : '0;
    assign depth     = depth_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_delay_line.sv
// Purpose: self-checking bench for delay_line; both storage variants run side by side against a queue model.
// Latency: model predicts output after each edge from the history of accepted beats since the last clear.
// Backpressure: en randomised; flush/cfg_load/reset injected directed and at random.
module tb_delay_line;

    localparam int W     = 8;
    localparam int L     = 4;
    localparam int M     = 12;
    localparam int DW    = $clog2(M + 1);
    localparam int DAT_W = W * L;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_load;
    logic [DW-1:0]    depth_cfg;
    logic             flush;
    logic             in_valid;
    logic [DAT_W-1:0] in_data;

    logic             a_out_valid, b_out_valid;
    logic [DAT_W-1:0] a_out_data,  b_out_data;
    logic [DW-1:0]    a_depth,     b_depth;
    logic             a_cfg_err,   b_cfg_err;

    // Reference model state
    logic [DAT_W:0]   hist [$];
    int               m_depth;
    logic             m_err;
    logic             exp_v;
    logic [DAT_W-1:0] exp_d;

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    delay_line #(.WIDTH(W), .LANES(L), .MAX_DEPTH(M), .BRAM(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .depth_cfg(depth_cfg),
        .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(a_out_valid), .out_data(a_out_data), .depth(a_depth), .cfg_err(a_cfg_err)
    );

    delay_line #(.WIDTH(W), .LANES(L), .MAX_DEPTH(M), .BRAM(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .depth_cfg(depth_cfg),
        .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_out_valid), .out_data(b_out_data), .depth(b_depth), .cfg_err(b_cfg_err)
    );

    function automatic logic [DAT_W-1:0] pat(input int k);
        logic [DAT_W-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) begin
            v[i*W +: W] = W'(k * L + i);
        end
        return v;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_depth = M;
        m_err   = 1'b0;
        exp_v   = 1'b0;
        exp_d   = '0;
    endtask

    // Behavioural update at an active edge, from the inputs that were presented.
    task automatic model_edge();
        if (!rst) return;
        if (cfg_load) begin
            if (int'(depth_cfg) == 0) begin
                m_depth = 1;
                m_err   = 1'b1;
            end else if (int'(depth_cfg) > M) begin
                m_depth = M;
                m_err   = 1'b1;
            end else begin
                m_depth = int'(depth_cfg);
                m_err   = 1'b0;
            end
        end
        if (cfg_load || flush) begin
            hist.delete();
            exp_v = 1'b0;
        end else if (en) begin
            hist.push_back({in_valid, in_data});
            if (hist.size() > M) void'(hist.pop_front());
            if (hist.size() >= m_depth) {exp_v, exp_d} = hist[hist.size() - m_depth];
            else exp_v = 1'b0;
        end
    endtask

    task automatic check_all();
        cmp("out_valid", 64'(b_out_valid), 64'(exp_v));
        if (exp_v) cmp("out_data", 64'(b_out_data), 64'(exp_d));
        cmp("depth", 64'(b_depth), 64'(m_depth));
        cmp("cfg_err", 64'(b_cfg_err), 64'(m_err));
        cmp("variant_valid", 64'(a_out_valid), 64'(b_out_valid));
        cmp("variant_data", 64'(a_out_data), 64'(b_out_data));
        cmp("variant_depth", 64'(a_depth), 64'(b_depth));
        cmp("variant_err", 64'(a_cfg_err), 64'(b_cfg_err));
    endtask

    task automatic drive(input logic e, input logic ld, input int cfg, input logic fl,
                         input logic iv, input logic [DAT_W-1:0] d);
        en        = e;
        cfg_load  = ld;
        depth_cfg = DW'(cfg);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset mid-stream: outputs must drop without waiting for an edge.
    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        #1;
        cmp("rst_valid_a", 64'(a_out_valid), 64'd0);
        cmp("rst_valid_b", 64'(b_out_valid), 64'd0);
        cmp("rst_data_a", 64'(a_out_data), 64'd0);
        cmp("rst_data_b", 64'(b_out_data), 64'd0);
        cmp("rst_depth", 64'(b_depth), 64'(M));
        cmp("rst_err", 64'(b_cfg_err), 64'd0);
        en       = 1'b1;
        in_valid = 1'b1;
        in_data  = $urandom;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_hold_valid", 64'(b_out_valid), 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        en = 1'b0; cfg_load = 1'b0; flush = 1'b0; in_valid = 1'b0;
        depth_cfg = '0; in_data = '0;
        rst = 1'b1;
        #2;
        apply_reset();

        // D=5 continuous stream
        drive(1'b0, 1'b1, 5, 1'b0, 1'b0, '0);
        for (int k = 0; k < 30; k++) drive(1'b1, 1'b0, 0, 1'b0, 1'b1, pat(k));

        // D=5 with en toggling
        drive(1'b0, 1'b1, 5, 1'b0, 1'b0, '0);
        for (int k = 0; k < 30; k++) drive(k % 2 == 0, 1'b0, 0, 1'b0, 1'b1, pat(100 + k));

        // D=1 and D=MAX across several wraps
        drive(1'b1, 1'b1, 1, 1'b0, 1'b1, pat(7));
        for (int k = 0; k < 3 * M; k++) drive(1'b1, 1'b0, 0, 1'b0, ($urandom % 4) != 0, $urandom);
        drive(1'b1, 1'b1, M, 1'b0, 1'b1, pat(9));
        for (int k = 0; k < 3 * M; k++) drive(1'b1, 1'b0, 0, 1'b0, ($urandom % 4) != 0, $urandom);

        // Out-of-range loads clamp and set the sticky error; a good load clears it
        drive(1'b1, 1'b1, 0, 1'b0, 1'b1, pat(1));
        drive(1'b1, 1'b0, 0, 1'b0, 1'b1, pat(2));
        drive(1'b1, 1'b1, M + 1, 1'b0, 1'b1, pat(3));
        drive(1'b1, 1'b0, 0, 1'b0, 1'b1, pat(4));
        drive(1'b0, 1'b1, 7, 1'b0, 1'b0, '0);

        // Flush at beat 10 with D=8
        drive(1'b0, 1'b1, 8, 1'b0, 1'b0, '0);
        for (int k = 0; k < 24; k++) drive(1'b1, 1'b0, 0, k == 10, 1'b1, pat(200 + k));

        // Random mix including loads, flushes and mid-stream resets
        for (int n = 0; n < 800; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0) begin
                apply_reset();
            end else begin
                drive(($urandom % 4) != 0, r < 3, $urandom_range(0, M + 2), (r >= 3) && (r < 6),
                      ($urandom % 3) != 0, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
